dma_priority_arbiter: RTL
=========================

# dma_priority_arbiter

Channel priority arbiter and bus-hold sequencer for the 8237A-5 DMA controller. It samples the four channel requests (hardware DREQ and software request register), applies masking and DREQ polarity, and raises HRQ to the host. When HLDA returns, it grants one channel with DACK and holds the grant until the timing-control block reports end of service. It sits between the ExternalBus pins and the internal timing/control FSM inside DMATop.

## Interface
- NUM_CH, 4, number of DMA channels; the design is verified at 4 only.
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high; clears all state.
- DREQ  input  NUM_CH  raw channel request pins; polarity set by DreqSenseLow.
- SwReq  input  NUM_CH  software request register bits; always active-high.
- Mask  input  NUM_CH  mask register; 1 = channel ignored.
- DreqSenseLow  input  1  command bit; 1 = DREQ active-low.
- DackSenseLow  input  1  command bit; 1 = DACK driven active-low.
- RotPri  input  1  command bit; 1 = rotating priority, 0 = fixed (ch0 highest). Present only with ROTATING_PRIORITY_EN.
- HLDA  input  1  hold acknowledge from the host.
- ServiceDone  input  1  one-cycle pulse from timing control: transfer complete or EOP.
- HRQ  output  1  hold request to the host.
- DACK  output  NUM_CH  one-hot grant, polarity per DackSenseLow.
- GrantValid  output  1  a channel is currently granted.
- GrantCh  output  2  index of the granted channel.
- SwReqClr  output  NUM_CH  one-cycle pulse that clears the serviced software request bit.

## Operation
- Effective request: req[i] = ~Mask[i] & ((DREQ[i] ^ DreqSenseLow) | SwReq[i]).
- States:
  - IDLE → REQ when any req is set.
  - REQ → GRANT when HLDA=1 and any req is set. The winner is arbitrated at this cycle, not at REQ entry.
  - REQ → RELEASE when HLDA=1 and no req is set.
  - GRANT → RELEASE on ServiceDone.
  - GRANT → IDLE on HLDA=0 (host abort). No priority update and no SwReqClr in this case.
  - RELEASE → IDLE when HLDA=0.
- Priority pointer (2-bit) gives the highest-priority channel; search proceeds upward modulo 4.
  - Fixed mode: pointer forced to 0.
  - Rotating mode: on ServiceDone the pointer becomes GrantCh+1 mod 4, so the serviced channel becomes lowest priority.
- The grant is held for the entire service. Request changes (including the granted channel's req dropping or being masked) do not preempt it.
- SwReqClr[GrantCh] pulses on ServiceDone if SwReq[GrantCh] was set.
- Reset values:
  - state IDLE, pointer 0, HRQ=0, GrantValid=0, GrantCh=0, SwReqClr=0.
  - DACK = all inactive, i.e. 4'b0000. DackSenseLow is ignored during reset.
- RESET asserted mid-operation drops HRQ and DACK immediately, without waiting for a clock edge.

## Timing
- HRQ is registered and rises on the first edge after req is sampled nonzero in IDLE.
- In REQ, HLDA sampled high at edge n produces DACK, GrantValid and GrantCh valid after edge n.
- ServiceDone sampled at edge n produces, after edge n: DACK inactive, GrantValid=0, HRQ=0, pointer updated, SwReqClr high for one cycle.
- HRQ stays low in RELEASE. A new HRQ rises no earlier than one cycle after HLDA is seen low.
- Simultaneous ServiceDone and HLDA=0 in GRANT: ServiceDone wins (RELEASE path), and the transition to IDLE follows on the next edge.
- DACK polarity follows DackSenseLow combinationally from the registered one-hot grant.

## Configuration
- ROTATING_PRIORITY_EN
  - Defined: the RotPri port and the pointer register exist, and rotation behaves as above.
  - Undefined: the port is absent, the pointer is a constant 0, and the arbiter is fixed priority only.

## Structure
- Shared package dma_pkg holds:
  - the arb_state_t enum (IDLE, REQ, GRANT, RELEASE);
  - the NUM_CH constant;
  - the chan_t 2-bit typedef.
- Sub-module dma_prio_encoder is combinational: it takes req and pointer and returns winner index plus valid. It is instantiated once.

## Test plan
- Fixed priority: DREQ=4'b1010, HLDA asserted 3 cycles after HRQ → DACK=4'b0010, GrantCh=1. After ServiceDone, a re-request with HLDA grants ch1 again.
- Rotating: RotPri=1, DREQ=4'b1111 held. Four service cycles grant ch0, ch1, ch2, ch3 in order, then ch0.
- Mask and polarity: DreqSenseLow=1, DREQ=4'b1110, Mask=4'b0001 → HRQ stays 0. Clearing Mask produces HRQ=1 next cycle. With DackSenseLow=1, the grant shows DACK=4'b1110.
- Software request: SwReq=4'b0100 → grant ch2. ServiceDone produces SwReqClr=4'b0100 for exactly one cycle.
- Late withdrawal: DREQ drops while in REQ, then HLDA=1 → no DACK; HRQ falls next cycle; IDLE is reached after HLDA=0.
- Abort and reset: HLDA drops in GRANT → IDLE with pointer unchanged. RESET asserted mid-grant → HRQ=0 and DACK=4'b0000 without waiting for a clock edge.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : dma_pkg                                                    |
// | Description : Shared types and constants for the 8237A-5 DMA channel     |
// |               arbiter: channel count, channel index type, arbiter state  |
// |               encoding and a one-hot helper.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package dma_pkg;

   // Number of DMA channels handled by the arbiter.
   localparam int NUM_CH = 4;

   // Channel index (0..NUM_CH-1).
   typedef logic [1:0] chan_t;

   // Arbiter / bus-hold sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // Convert a channel index into a one-hot channel vector.
   function automatic logic [NUM_CH-1:0] chan_onehot(input chan_t ch);
      logic [NUM_CH-1:0] oh;
      oh     = '0;
      oh[ch] = 1'b1;
      return oh;
   endfunction

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_prio_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dma_prio_encoder                                           |
// | Description : Combinational rotating-priority encoder. Starting at the   |
// |               channel named by the priority pointer, searches upward     |
// |               (modulo NUM_CH) and returns the first requesting channel.  |
// | Ports       : req    in  [NUM_CH-1:0] effective channel requests         |
// |               ptr    in  chan_t       highest-priority channel           |
// |               winner out chan_t       index of the winning channel       |
// |               valid  out 1            at least one request is present    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dma_prio_encoder
   import dma_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [1:0]        ptr,
   output logic [1:0]        winner,
   output logic              valid
);

   assign valid = |req;

   // Scan from the lowest-priority offset down to offset 0 so that the
   // last match written (the smallest offset from ptr) wins.
   always_comb begin
      chan_t idx;
      idx    = ptr;
      winner = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = ptr + chan_t'(k);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

endmodule : dma_prio_encoder
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dma_priority_arbiter                                       |
// | Description : Channel priority arbiter and bus-hold sequencer for the    |
// |               8237A-5 DMA controller. Forms the effective request per    |
// |               channel, raises HRQ, grants one channel with DACK once     |
// |               HLDA returns and holds that grant until ServiceDone.       |
// | Build macro : ROTATING_PRIORITY_EN - when defined, adds the RotPri port  |
// |               and the rotating priority pointer; otherwise the arbiter   |
// |               is fixed priority (ch0 highest).                           |
// | Ports       : CLOCK        in   system clock (rising edge)               |
// |               RESET        in   asynchronous active-high reset           |
// |               DREQ         in   raw channel request pins                 |
// |               SwReq        in   software request bits (active-high)      |
// |               Mask         in   channel mask (1 = ignored)               |
// |               DreqSenseLow in   1 = DREQ active-low                      |
// |               DackSenseLow in   1 = DACK active-low                      |
// |               RotPri       in   1 = rotating priority (macro only)       |
// |               HLDA         in   hold acknowledge from host               |
// |               ServiceDone  in   end-of-service pulse from timing control |
// |               HRQ          out  hold request to host                     |
// |               DACK         out  one-hot grant, polarity per DackSenseLow |
// |               GrantValid   out  a channel is currently granted           |
// |               GrantCh      out  index of the granted channel             |
// |               SwReqClr     out  one-cycle clear for serviced SwReq bit   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dma_priority_arbiter
   import dma_pkg::*;
(
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic [NUM_CH-1:0] SwReq,
   input  logic [NUM_CH-1:0] Mask,
   input  logic              DreqSenseLow,
   input  logic              DackSenseLow,
`ifdef ROTATING_PRIORITY_EN
   input  logic              RotPri,
`endif
   input  logic              HLDA,
   input  logic              ServiceDone,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              GrantValid,
   output logic [1:0]        GrantCh,
   output logic [NUM_CH-1:0] SwReqClr
);

   // ------------------------------------------------------------------
   // Effective requests
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] w_req;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_req
      assign w_req[i] = ~Mask[i] & ((DREQ[i] ^ DreqSenseLow) | SwReq[i]);
   end

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   arb_state_t        r_state;
   logic              r_hrq;
   logic              r_grant_valid;
   logic [1:0]        r_grant_ch;
   logic [NUM_CH-1:0] r_grant_oh;
   logic [NUM_CH-1:0] r_swreq_clr;

   // ------------------------------------------------------------------
   // Priority pointer
   // ------------------------------------------------------------------
   logic [1:0] w_ptr;

`ifdef ROTATING_PRIORITY_EN
   logic [1:0] r_ptr;

   // Fixed mode pins the pointer to 0. In rotating mode a completed
   // service makes the serviced channel the lowest priority. A host
   // abort leaves the pointer untouched.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_ptr <= '0;
      end else if (!RotPri) begin
         r_ptr <= '0;
      end else if (r_state == GRANT && ServiceDone) begin
         r_ptr <= r_grant_ch + 2'd1;
      end
   end

   // Mask the pointer combinationally as well, so switching to fixed
   // mode takes effect in the same cycle.
   assign w_ptr = RotPri ? r_ptr : 2'd0;
`else
   assign w_ptr = 2'd0;
`endif

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
   logic [1:0] w_winner;
   logic       w_win_valid;

   dma_prio_encoder u_prio_encoder (
      .req    (w_req),
      .ptr    (w_ptr),
      .winner (w_winner),
      .valid  (w_win_valid)
   );

   // ------------------------------------------------------------------
   // Bus-hold sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state       <= IDLE;
         r_hrq         <= 1'b0;
         r_grant_valid <= 1'b0;
         r_grant_ch    <= '0;
         r_grant_oh    <= '0;
         r_swreq_clr   <= '0;
      end else begin
         // SwReqClr is a single-cycle pulse.
         r_swreq_clr <= '0;

         case (r_state)
            IDLE: begin
               if (w_win_valid) begin
                  r_state <= REQ;
                  r_hrq   <= 1'b1;
               end
            end

            REQ: begin
               // The winner is chosen when HLDA arrives, not when HRQ
               // was raised, so late requests can still take the bus.
               if (HLDA) begin
                  if (w_win_valid) begin
                     r_state       <= GRANT;
                     r_grant_valid <= 1'b1;
                     r_grant_ch    <= w_winner;
                     r_grant_oh    <= chan_onehot(w_winner);
                  end else begin
                     // Requests withdrew before the host answered.
                     r_state <= RELEASE;
                     r_hrq   <= 1'b0;
                  end
               end
            end

            GRANT: begin
               // Request changes are ignored here: the grant is held
               // until service ends or the host takes the bus back.
               // ServiceDone takes precedence over a simultaneous abort.
               if (ServiceDone) begin
                  r_state       <= RELEASE;
                  r_hrq         <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_grant_oh    <= '0;
                  if (SwReq[r_grant_ch]) begin
                     r_swreq_clr <= chan_onehot(r_grant_ch);
                  end
               end else if (!HLDA) begin
                  r_state       <= IDLE;
                  r_hrq         <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_grant_oh    <= '0;
               end
            end

            RELEASE: begin
               // Hold HRQ low until the host has dropped HLDA.
               if (!HLDA) begin
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign HRQ        = r_hrq;
   assign GrantValid = r_grant_valid;
   assign GrantCh    = r_grant_ch;
   assign SwReqClr   = r_swreq_clr;

   // During reset DACK is forced to all-zero regardless of polarity, so
   // the pins are quiet even before DackSenseLow has been programmed.
   assign DACK = RESET ? '0 : (r_grant_oh ^ {NUM_CH{DackSenseLow}});

endmodule : dma_priority_arbiter
`default_nettype wire
